// File: rtl/pr_dec_ack.sv
// pr_dec_ack: interrupt grant/acknowledge stage placed after a priority encoder.
// It takes an encoded request index and drives a registered one-hot acknowledge
// to that requester. The acknowledge is held until the requester reports
// completion, or until a service timeout when the timeout feature is built in.
// One RELEASE cycle follows, and then the block re-arms.
//
// Optional feature macro: PR_DEC_TIMEOUT_EN.
//   defined   : service timer, timeout abort and err_out pulse.
//   undefined : no timer; ACTIVE waits for done_in indefinitely; err_out = 0.
//
// Ports:
//   clk          in   clock; all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   y_in         in   encoded request index (IDX_WIDTH)
//   valid_in     in   y_in is meaningful
//   ready_out    out  block can accept a request (IDLE)
//   done_in      in   requester finished servicing; only looked at in ACTIVE
//   ack_out      out  registered one-hot grant (DATA_WIDTH)
//   busy_out     out  high in ACTIVE and RELEASE
//   err_out      out  one-cycle pulse during RELEASE after a timeout abort
//   last_idx_out out  index of the most recently accepted request
//   svc_cnt_out  out  completed (non-timeout) services, wraps 255 -> 0
module pr_dec_ack #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_WIDTH-1:0]  y_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  done_in,
    output logic [DATA_WIDTH-1:0] ack_out,
    output logic                  busy_out,
    output logic                  err_out,
    output logic [IDX_WIDTH-1:0]  last_idx_out,
    output logic [7:0]            svc_cnt_out
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StRelease
    } state_e;

    state_e                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_ack, w_ack_nxt;
    logic [IDX_WIDTH-1:0]  r_last_idx, w_last_idx_nxt;
    logic [7:0]            r_svc_cnt, w_svc_cnt_nxt;

`ifdef PR_DEC_TIMEOUT_EN
    logic [7:0] r_timer, w_timer_nxt;
    logic       r_err, w_err_nxt;
    logic       w_timeout;

    // Timer holds the number of ACTIVE cycles already spent; the last allowed
    // cycle is the one where it reads TIMEOUT_CYC-1.
    assign w_timeout = (r_timer == 8'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = r_ack;
        w_last_idx_nxt = r_last_idx;
        w_svc_cnt_nxt  = r_svc_cnt;
`ifdef PR_DEC_TIMEOUT_EN
        w_timer_nxt    = r_timer;
        // Error flag lives only for the RELEASE cycle that follows an abort.
        w_err_nxt      = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (valid_in) begin
                    w_last_idx_nxt = y_in;
                    w_ack_nxt      = DATA_WIDTH'(1) << y_in;
                    w_state_nxt    = StActive;
`ifdef PR_DEC_TIMEOUT_EN
                    w_timer_nxt    = 8'd0;
`endif
                end
            end
            StActive: begin
                // done_in takes priority over a simultaneous timeout.
                if (done_in) begin
                    w_ack_nxt     = '0;
                    w_svc_cnt_nxt = r_svc_cnt + 8'd1;
                    w_state_nxt   = StRelease;
                end
`ifdef PR_DEC_TIMEOUT_EN
                else if (w_timeout) begin
                    w_ack_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = StRelease;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
`endif
            end
            StRelease: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_ack_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_ack      <= '0;
            r_last_idx <= '0;
            r_svc_cnt  <= 8'd0;
`ifdef PR_DEC_TIMEOUT_EN
            r_timer    <= 8'd0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= w_ack_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_svc_cnt  <= w_svc_cnt_nxt;
`ifdef PR_DEC_TIMEOUT_EN
            r_timer    <= w_timer_nxt;
            r_err      <= w_err_nxt;
`endif
        end
    end

    assign ready_out    = (r_state == StIdle);
    assign busy_out     = (r_state != StIdle);
    assign ack_out      = r_ack;
    assign last_idx_out = r_last_idx;
    assign svc_cnt_out  = r_svc_cnt;
`ifdef PR_DEC_TIMEOUT_EN
    assign err_out      = r_err;
`else
    assign err_out      = 1'b0;
`endif

endmodule

// File: tb/tb_pr_dec_ack.sv
// Testbench for pr_dec_ack: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_pr_dec_ack;

    localparam int unsigned DW = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 4;
`ifdef PR_DEC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] y_in = '0;
    logic          valid_in = 1'b0;
    logic          done_in = 1'b0;
    logic          ready_out;
    logic [DW-1:0] ack_out;
    logic          busy_out;
    logic          err_out;
    logic [IW-1:0] last_idx_out;
    logic [7:0]    svc_cnt_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pr_dec_ack #(
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .y_in        (y_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .done_in     (done_in),
        .ack_out     (ack_out),
        .busy_out    (busy_out),
        .err_out     (err_out),
        .last_idx_out(last_idx_out),
        .svc_cnt_out (svc_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: "granted" means a requester holds the ack; "cooling"
    // is the single settle cycle after a grant ends; otherwise the block is free.
    bit     m_granted = 1'b0;
    bit     m_cooling = 1'b0;
    bit     m_aborted = 1'b0;
    int     m_grant   = 0;
    int     m_held    = 0;  // cycles the current grant has been held
    int     m_last    = 0;
    int     m_done    = 0;  // completed services since reset

    always @(posedge clk) begin
        if (rst) begin
            m_granted = 1'b0;
            m_cooling = 1'b0;
            m_aborted = 1'b0;
            m_last    = 0;
            m_done    = 0;
        end else if (m_cooling) begin
            m_cooling = 1'b0;
            m_aborted = 1'b0;
        end else if (m_granted) begin
            m_held = m_held + 1;
            if (done_in) begin
                m_done    = m_done + 1;
                m_granted = 1'b0;
                m_cooling = 1'b1;
            end else if (TO_EN && m_held == TO) begin
                m_granted = 1'b0;
                m_cooling = 1'b1;
                m_aborted = 1'b1;
            end
        end else if (valid_in) begin
            m_granted = 1'b1;
            m_grant   = int'(y_in);
            m_last    = int'(y_in);
            m_held    = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ack", 32'(ack_out), m_granted ? (32'd1 << m_grant) : 32'd0);
            check("model_ready", 32'(ready_out), 32'(!m_granted && !m_cooling));
            check("model_busy", 32'(busy_out), 32'(m_granted || m_cooling));
            check("model_err", 32'(err_out), 32'(m_cooling && m_aborted));
            check("model_last", 32'(last_idx_out), 32'(m_last));
            check("model_svc", 32'(svc_cnt_out), 32'(m_done % 256));
            check("onehot", 32'($countones(ack_out) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic service(input logic [IW-1:0] idx, input int extra);
        valid_in = 1'b1;
        y_in     = idx;
        tick();
        valid_in = 1'b0;
        repeat (extra) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack_out), 32'h0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_svc", 32'(svc_cnt_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);

        // Single service of requester 2
        tick();
        valid_in = 1'b1;
        y_in     = 2'd2;
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        check("single_ack", 32'(ack_out), 32'b0100);
        check("single_busy", 32'(busy_out), 32'd1);
        tick();
        tick();
        done_in = 1'b1;
        @(negedge clk);
        check("single_ack_hold", 32'(ack_out), 32'b0100);
        tick();
        done_in = 1'b0;
        @(negedge clk);
        check("single_rel_ack", 32'(ack_out), 32'h0);
        check("single_rel_ready", 32'(ready_out), 32'd0);
        check("single_svc", 32'(svc_cnt_out), 32'd1);
        check("single_last", 32'(last_idx_out), 32'd2);
        tick();
        @(negedge clk);
        check("single_rearm", 32'(ready_out), 32'd1);

        // Back-to-back: valid held, y changes while busy
        valid_in = 1'b1;
        y_in     = 2'd3;
        tick();
        y_in    = 2'd0;
        done_in = 1'b1;
        @(negedge clk);
        check("b2b_ack0", 32'(ack_out), 32'b1000);
        tick();
        @(negedge clk);
        check("b2b_ack1", 32'(ack_out), 32'b0000);
        tick();
        @(negedge clk);
        check("b2b_ack2", 32'(ack_out), 32'b0000);
        check("b2b_idle_ready", 32'(ready_out), 32'd1);
        tick();
        @(negedge clk);
        check("b2b_ack3", 32'(ack_out), 32'b0001);
        tick();
        valid_in = 1'b0;
        done_in  = 1'b0;
        tick();
        check("b2b_svc", 32'(svc_cnt_out), 32'd3);

        // Timeout: requester 1, no done
        valid_in = 1'b1;
        y_in     = 2'd1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check("to_ack_held", 32'(ack_out), 32'b0010);
            tick();
        end
        @(negedge clk);
        if (TO_EN) begin
            check("to_err", 32'(err_out), 32'd1);
            check("to_ack_clr", 32'(ack_out), 32'h0);
            check("to_svc", 32'(svc_cnt_out), 32'd3);
            tick();
            @(negedge clk);
            check("to_err_pulse", 32'(err_out), 32'd0);
        end else begin
            repeat (20) tick();
            @(negedge clk);
            check("noto_ack_held", 32'(ack_out), 32'b0010);
            check("noto_err", 32'(err_out), 32'd0);
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
            tick();
        end
        tick();

        // Collision: done on the last allowed ACTIVE cycle
        valid_in = 1'b1;
        y_in     = 2'd1;
        tick();
        valid_in = 1'b0;
        repeat (TO - 1) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        @(negedge clk);
        check("coll_err", 32'(err_out), 32'd0);
        check("coll_svc", 32'(svc_cnt_out), TO_EN ? 32'd4 : 32'd5);
        tick();

        // Reset mid-ACTIVE
        valid_in = 1'b1;
        y_in     = 2'd3;
        tick();
        valid_in = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ack", 32'(ack_out), 32'h0);
        check("midrst_ready", 32'(ready_out), 32'd1);
        check("midrst_err", 32'(err_out), 32'd0);

        // Counter wrap after 256 completed services
        for (int i = 0; i < 255; i++) begin
            service(IW'($urandom_range(0, DW - 1)), int'($urandom_range(0, 2)));
        end
        @(negedge clk);
        check("svc_255", 32'(svc_cnt_out), 32'd255);
        service(2'd2, 0);
        @(negedge clk);
        check("svc_wrap", 32'(svc_cnt_out), 32'd0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            valid_in = ($urandom_range(0, 2) != 0);
            y_in     = IW'($urandom_range(0, DW - 1));
            done_in  = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst      = 1'b0;
        valid_in = 1'b0;
        done_in  = 1'b0;
        tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
